ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch stage of the multi-cycle NPC core, directly upstream of the decode stage. Owns the PC and issues one AXI4-Lite read-address request per instruction. Hands `{pc, snpc}` to decode with a one-cycle valid pulse, then snoops the R-channel handshake that decode completes. Waits for the writeback-stage redirect carrying the next PC before fetching again.

## Interface
Parameters:
- `RESET_PC`, `32'h3000_0000`, PC loaded on reset.
- `TIMEOUT`, `255`, maximum cycles tolerated in ADDR or DATA before a bus hang is declared; legal range 2..255.

Ports (one clock; reset is synchronous and active-low):
- `clock`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled at the rising edge, 0 = reset.
- `redirect_valid_i`  in  1  writeback has retired the current instruction.
- `redirect_pc_i`  in  32  next PC, valid with `redirect_valid_i`.
- `araddr_o`  out  32  AXI read address (= current pc).
- `arvalid_o`  out  1  AXI read address valid.
- `arready_i`  in  1  AXI read address ready.
- `arsize_o`  out  3  constant `3'b010` (4 bytes).
- `rvalid_i`  in  1  R-channel valid (snooped).
- `rready_i`  in  1  R-channel ready driven by decode (snooped).
- `ifu_bdu_bus_o`  out  64  `{pc, snpc}`, pc in [63:32].
- `valid_o`  out  1  one-cycle pulse; decode latches `ifu_bdu_bus_o` on it.
- `busy_o`  out  1  high in ADDR, DATA, EXEC.
- `timeout_o`  out  1  sticky, bus hang detected.
- `misalign_o`  out  1  sticky, redirect target with pc[1:0] != 0.
- `fetch_cnt_o`  out  32  completed fetches, wraps at 2^32.

## Operation
- States: BOOT, ADDR, DATA, EXEC, HALT. Reset forces BOOT.
- BOOT -> ADDR unconditionally, after one cycle.
- ADDR: `arvalid_o`=1 and `araddr_o`=pc, both held stable until `arready_i`. On the handshake, go to DATA and pulse `valid_o` in the next cycle.
- DATA: on `rvalid_i & rready_i`, go to EXEC and increment `fetch_cnt_o`.
- EXEC: on `redirect_valid_i`:
  - If `redirect_pc_i[1:0]==0`: pc <= `redirect_pc_i`, go to ADDR.
  - Otherwise: set `misalign_o`, go to HALT; pc is unchanged.
- `redirect_valid_i` outside EXEC is ignored; no state or pc change.
- snpc = pc + 32'd4, mod 2^32. pc 32'hFFFF_FFFC gives snpc 0.
- Hang counter (8 bits):
  - Cleared on entry to ADDR and to DATA.
  - Increments each ADDR/DATA cycle without the awaited handshake.
  - When it reaches `TIMEOUT`-1 in a cycle with no handshake: set `timeout_o`, go to HALT.
  - A handshake on that same cycle wins; no timeout.
- HALT: all outputs frozen except `busy_o`=0 and `arvalid_o`=0. Exit only via reset.
- Reset mid-transaction: state BOOT, `arvalid_o` drops at that edge, all outstanding bus activity is abandoned.

## Timing
- Reset values: `arvalid_o`=0, `valid_o`=0, `araddr_o`=`RESET_PC`, `ifu_bdu_bus_o`={`RESET_PC`, `RESET_PC`+4}, `busy_o`=0, `timeout_o`=0, `misalign_o`=0, `fetch_cnt_o`=0.
- After reset releases at edge E0: BOOT during E0..E1, `arvalid_o`=1 from E1.
- `arvalid_o` and `busy_o` are decoded from registered state, so they are glitch-free.
- `valid_o` is registered: high exactly one cycle, the first DATA cycle. `ifu_bdu_bus_o` is stable from the ADDR cycle through EXEC.
- An R handshake may coincide with the `valid_o` cycle; this is legal and completes DATA.
- Minimum fetch loop: ADDR(1) + DATA(1) + EXEC(1) = 3 cycles per instruction when arready, rvalid and redirect are all immediate.
- Redirect accepted at edge En gives `arvalid_o`=1 with the new `araddr_o` during cycle En..En+1.

## Test plan
- Reset, arready tied 1, rvalid 1 cycle after valid_o, redirect 0x30000004 -> araddr 0x30000000 then 0x30000004; valid_o one pulse per fetch; bus = {0x30000000, 0x30000004}; fetch_cnt 1 then 2.
- arready held low 5 cycles -> arvalid_o and araddr_o stable all 5 cycles; valid_o only after the handshake.
- TIMEOUT=4, arready never asserted -> timeout_o=1 at the 4th ADDR cycle, arvalid_o=0, busy_o=0; arready on exactly the 4th cycle -> no timeout.
- Redirect pc 0x30000006 in EXEC -> misalign_o=1, HALT, no further AR request; redirect pulses in ADDR/DATA -> ignored, pc unchanged.
- Redirect 0xFFFFFFFC -> bus {0xFFFFFFFC, 0x00000000}; reset asserted while in DATA -> next cycle arvalid_o=0, all outputs at reset values.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: fetch-stage bus bundle (AXI4-Lite AR channel, R-channel snoop, decode hand-off, redirect).
interface ifu_fetch_if;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [2:0]  arsize_o;
    logic        rvalid_i;
    logic        rready_i;
    logic [63:0] ifu_bdu_bus_o;
    logic        valid_o;
    logic        busy_o;
    logic        timeout_o;
    logic        misalign_o;
    logic [31:0] fetch_cnt_o;
    modport master (
        input  redirect_valid_i, redirect_pc_i, arready_i, rvalid_i, rready_i,
        output araddr_o, arvalid_o, arsize_o, ifu_bdu_bus_o, valid_o, busy_o,
               timeout_o, misalign_o, fetch_cnt_o
    );
    modport slave (
        output redirect_valid_i, redirect_pc_i, arready_i, rvalid_i, rready_i,
        input  araddr_o, arvalid_o, arsize_o, ifu_bdu_bus_o, valid_o, busy_o,
               timeout_o, misalign_o, fetch_cnt_o
    );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage; owns the pc, issues one AR request per instruction,
// hands {pc, snpc} to decode and waits for the writeback redirect.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000,
    parameter int          TIMEOUT  = 255
) (
    input logic        clock,
    input logic        reset,
    ifu_fetch_if.master bus
);
    localparam logic [7:0] HANG_MAX = 8'(TIMEOUT - 1);
    typedef enum logic [2:0] {BOOT, ADDR, DATA, EXEC, HALT} state_t;
    state_t      state;
    logic [31:0] pc;
    logic [31:0] fetch_cnt;
    logic [7:0]  hang;
    logic        valid;
    logic        timeout;
    logic        misalign;
    logic        r_hs;
    logic        waiting;
    assign r_hs    = bus.rvalid_i & bus.rready_i;
    assign waiting = (state == ADDR && !bus.arready_i) || (state == DATA && !r_hs);
    // Every entry into ADDR/DATA comes from a non-waiting cycle, so the counter restarts at zero.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            fetch_cnt <= 32'd0;
            hang      <= 8'd0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            valid <= state == ADDR && bus.arready_i;
            hang  <= waiting ? hang + 8'd1 : 8'd0;
            case (state)
                BOOT: state <= ADDR;
                ADDR: if (bus.arready_i) state <= DATA;
                      else if (hang == HANG_MAX) begin
                          timeout <= 1'b1;
                          state   <= HALT;
                      end
                DATA: if (r_hs) begin
                          state     <= EXEC;
                          fetch_cnt <= fetch_cnt + 32'd1;
                      end else if (hang == HANG_MAX) begin
                          timeout <= 1'b1;
                          state   <= HALT;
                      end
                EXEC: if (bus.redirect_valid_i) begin
                          if (bus.redirect_pc_i[1:0] == 2'b00) begin
                              pc    <= bus.redirect_pc_i;
                              state <= ADDR;
                          end else begin
                              misalign <= 1'b1;
                              state    <= HALT;
                          end
                      end
                default: state <= state;
            endcase
        end
    end
    assign bus.araddr_o      = pc;
    assign bus.arvalid_o     = state == ADDR;
    assign bus.arsize_o      = 3'b010;
    assign bus.ifu_bdu_bus_o = {pc, pc + 32'd4};
    assign bus.valid_o       = valid;
    assign bus.busy_o        = state == ADDR || state == DATA || state == EXEC;
    assign bus.timeout_o     = timeout;
    assign bus.misalign_o    = misalign;
    assign bus.fetch_cnt_o   = fetch_cnt;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed + randomized fetch transactions checked against a transaction-level model.
module tb_ifu_fetch;
    localparam logic [31:0] RPC = 32'h3000_0000;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic reset4 = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    ifu_fetch_if bif();
    ifu_fetch_if bif4();
    ifu_fetch #(.RESET_PC(RPC), .TIMEOUT(16)) dut  (.clock(clock), .reset(reset),  .bus(bif));
    ifu_fetch #(.RESET_PC(RPC), .TIMEOUT(4))  dut4 (.clock(clock), .reset(reset4), .bus(bif4));
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic chk1(input string tag, input logic got, input logic exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask
    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    task automatic chk_reset_main(input string tag);
        chk1 ({tag, " arvalid"},  bif.arvalid_o, 1'b0);
        chk1 ({tag, " valid"},    bif.valid_o, 1'b0);
        chk32({tag, " araddr"},   bif.araddr_o, RPC);
        chk64({tag, " bus"},      bif.ifu_bdu_bus_o, {RPC, RPC + 32'd4});
        chk1 ({tag, " busy"},     bif.busy_o, 1'b0);
        chk1 ({tag, " timeout"},  bif.timeout_o, 1'b0);
        chk1 ({tag, " misalign"}, bif.misalign_o, 1'b0);
        chk32({tag, " cnt"},      bif.fetch_cnt_o, 32'd0);
    endtask

    // One instruction, entered in the first ADDR cycle; redirect pulses during ADDR/DATA must be ignored.
    task automatic fetch(input int ar_d, input int r_d, input int rd_d, input logic [31:0] target);
        for (int i = 0; i <= ar_d; i++) begin
            chk1 ("addr arvalid", bif.arvalid_o, 1'b1);
            chk32("addr araddr",  bif.araddr_o, m_pc);
            chk64("addr bus",     bif.ifu_bdu_bus_o, {m_pc, m_pc + 32'd4});
            chk1 ("addr valid",   bif.valid_o, 1'b0);
            chk1 ("addr busy",    bif.busy_o, 1'b1);
            bif.arready_i        = (i == ar_d);
            bif.redirect_valid_i = 1'($urandom_range(0, 1));
            bif.redirect_pc_i    = $urandom;
            tick();
        end
        bif.arready_i = 1'b0;
        for (int i = 0; i <= r_d; i++) begin
            chk1 ("data valid",   bif.valid_o, i == 0);
            chk1 ("data arvalid", bif.arvalid_o, 1'b0);
            chk1 ("data busy",    bif.busy_o, 1'b1);
            chk64("data bus",     bif.ifu_bdu_bus_o, {m_pc, m_pc + 32'd4});
            chk32("data cnt",     bif.fetch_cnt_o, m_cnt);
            if (i == r_d) begin
                bif.rvalid_i = 1'b1;
                bif.rready_i = 1'b1;
            end else begin
                bif.rvalid_i = 1'($urandom_range(0, 1));
                bif.rready_i = !bif.rvalid_i;
            end
            bif.redirect_valid_i = 1'($urandom_range(0, 1));
            bif.redirect_pc_i    = $urandom;
            tick();
        end
        bif.rvalid_i = 1'b0;
        bif.rready_i = 1'b0;
        m_cnt = m_cnt + 32'd1;
        for (int i = 0; i <= rd_d; i++) begin
            chk32("exec cnt",     bif.fetch_cnt_o, m_cnt);
            chk1 ("exec busy",    bif.busy_o, 1'b1);
            chk1 ("exec arvalid", bif.arvalid_o, 1'b0);
            chk1 ("exec valid",   bif.valid_o, 1'b0);
            chk64("exec bus",     bif.ifu_bdu_bus_o, {m_pc, m_pc + 32'd4});
            bif.redirect_valid_i = (i == rd_d);
            bif.redirect_pc_i    = target;
            tick();
        end
        bif.redirect_valid_i = 1'b0;
        if (target[1:0] == 2'b00) m_pc = target;
    endtask

    initial begin
        bif.redirect_valid_i = 1'b0; bif.redirect_pc_i = 32'd0; bif.arready_i = 1'b0;
        bif.rvalid_i = 1'b0; bif.rready_i = 1'b0;
        bif4.redirect_valid_i = 1'b0; bif4.redirect_pc_i = 32'd0; bif4.arready_i = 1'b0;
        bif4.rvalid_i = 1'b0; bif4.rready_i = 1'b0;
        tick();
        tick();
        chk_reset_main("reset");
        chk1("reset arsize", bif.arsize_o == 3'b010, 1'b1);
        reset = 1'b1;
        tick();
        m_pc  = RPC;
        m_cnt = 32'd0;
        fetch(0, 1, 0, 32'h3000_0004);
        chk32("first redirect araddr", bif.araddr_o, 32'h3000_0004);
        chk32("first cnt", bif.fetch_cnt_o, 32'd1);
        fetch(5, 0, 2, 32'h3000_0100);
        chk32("second cnt", bif.fetch_cnt_o, 32'd2);
        for (int k = 0; k < 16; k++)
            fetch($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 3), $urandom & 32'hFFFF_FFFC);
        fetch(1, 1, 1, 32'hFFFF_FFFC);
        chk64("wrap bus", bif.ifu_bdu_bus_o, 64'hFFFF_FFFC_0000_0000);
        fetch(0, 0, 0, 32'h3000_0006);
        for (int i = 0; i < 4; i++) begin
            chk1 ("halt misalign", bif.misalign_o, 1'b1);
            chk1 ("halt arvalid",  bif.arvalid_o, 1'b0);
            chk1 ("halt busy",     bif.busy_o, 1'b0);
            chk32("halt araddr",   bif.araddr_o, 32'hFFFF_FFFC);
            chk32("halt cnt",      bif.fetch_cnt_o, m_cnt);
            bif.arready_i        = 1'b1;
            bif.redirect_valid_i = 1'b1;
            bif.redirect_pc_i    = 32'h3000_0000;
            tick();
        end
        bif.arready_i        = 1'b0;
        bif.redirect_valid_i = 1'b0;
        reset = 1'b0;
        tick();
        chk_reset_main("halt reset");
        reset = 1'b1;
        tick();
        chk1("restart arvalid", bif.arvalid_o, 1'b1);
        bif.arready_i = 1'b1;
        tick();
        bif.arready_i = 1'b0;
        chk1("pre-reset valid", bif.valid_o, 1'b1);
        reset = 1'b0;
        tick();
        chk_reset_main("data reset");
        reset = 1'b1;
        tick();
        chk1("timeout reset", bif4.timeout_o, 1'b0);
        reset4 = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            chk1("to arvalid", bif4.arvalid_o, 1'b1);
            chk1("to pending", bif4.timeout_o, 1'b0);
            tick();
        end
        chk1("to timeout", bif4.timeout_o, 1'b1);
        chk1("to arvalid off", bif4.arvalid_o, 1'b0);
        chk1("to busy off", bif4.busy_o, 1'b0);
        tick();
        chk1("to sticky", bif4.timeout_o, 1'b1);
        reset4 = 1'b0;
        tick();
        reset4 = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            bif4.arready_i = (i == 4);
            tick();
        end
        bif4.arready_i = 1'b0;
        chk1("late hs timeout", bif4.timeout_o, 1'b0);
        chk1("late hs valid", bif4.valid_o, 1'b1);
        chk1("late hs busy", bif4.busy_o, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
